// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline hazard controller.
//   - RV32 opcode constants used to decide which source registers an
//     instruction in ID actually reads.
//   - Controller state encoding (RUN / FLUSH / MEM_WAIT) and its width.
//   - Width of the internal flush-cycle counter (FLUSH_CYCLES is 1..7).
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    localparam int STATE_W = 2;
    localparam int FCNT_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard detector.
// Ports:
//   ifid_inst    in  32  instruction in ID (rs1=[19:15], rs2=[24:20], opcode=[6:0])
//   idex_memRead in  1   instruction in EX is a load
//   idex_rd      in  5   destination register of the instruction in EX
//   load_use     out 1   ID reads a register the EX load has not produced yet
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] ifid_inst,
    input  logic        idex_memRead,
    input  logic [4:0]  idex_rd,
    output logic        load_use
);

    logic [6:0] opcode_s;
    logic [4:0] rs1_s;
    logic [4:0] rs2_s;
    logic       rs1_used_s;
    logic       rs2_used_s;
    logic       unused_inst_s;

    assign opcode_s = ifid_inst[6:0];
    assign rs1_s    = ifid_inst[19:15];
    assign rs2_s    = ifid_inst[24:20];

    // The rs fields of U/J-type encodings hold immediate bits, not registers.
    assign rs1_used_s = !((opcode_s == OP_LUI) || (opcode_s == OP_AUIPC) || (opcode_s == OP_JAL));
    assign rs2_used_s = (opcode_s == OP_R) || (opcode_s == OP_S) || (opcode_s == OP_B);

    // x0 is never a real dependency.
    assign load_use = idex_memRead && (idex_rd != 5'd0) &&
                      ((rs1_used_s && (rs1_s == idex_rd)) || (rs2_used_s && (rs2_s == idex_rd)));

    assign unused_inst_s = ^{ifid_inst[31:25], ifid_inst[14:7]};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the 5-stage pipeline.
// Drives write-enables / flushes of PC, IF/ID, ID/EX and the EX/MEM hold.
// Outputs respond combinationally to current inputs and registered state.
// Parameters: FLUSH_CYCLES (1..7) cycles of flush per taken branch,
//             CNT_W width of the performance counters.
// Optional feature macro: HAZARD_PERF_CNT_EN -- when defined, stall_cnt and
// flush_cnt are saturating counters; otherwise they are tied to zero.
// Ports:
//   clk, rst (synchronous, active-low)
//   ifid_inst, idex_memRead, idex_rd  hazard decode inputs
//   branch_taken, dmem_busy           EX redirect / MEM wait inputs
//   pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold  pipeline controls
//   state_o                           current state (debug)
//   stall_cnt, flush_cnt              performance counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        ifid_inst,
    input  logic               idex_memRead,
    input  logic [4:0]         idex_rd,
    input  logic               branch_taken,
    input  logic               dmem_busy,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               exmem_hold,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FCNT_ONE   = FCNT_W'(1);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [FCNT_W-1:0] fcnt_r;      // flush cycles still owed, including the current one
    logic [FCNT_W-1:0] fcnt_nxt_s;
    logic              pend_r;      // branch seen while memory was busy
    logic              pend_nxt_s;
    logic              load_use_s;
    logic              do_hold_s;
    logic              do_flush_s;
    logic              stall_inc_s;
    logic              flush_inc_s;

    hazard_detect u_hazard_detect (
        .ifid_inst    (ifid_inst),
        .idex_memRead (idex_memRead),
        .idex_rd      (idex_rd),
        .load_use     (load_use_s)
    );

    // Classify the cycle: memory hold wins, then an owed flush, else normal decode.
    always_comb begin
        do_hold_s  = 1'b0;
        do_flush_s = 1'b0;
        case (state_r)
            RUN: begin
                do_hold_s = dmem_busy;
            end
            FLUSH: begin
                do_hold_s  = dmem_busy;
                do_flush_s = !dmem_busy;
            end
            MEM_WAIT: begin
                do_hold_s  = dmem_busy;
                do_flush_s = !dmem_busy && (pend_r || (fcnt_r != '0));
            end
            default: begin
                do_hold_s = dmem_busy;
            end
        endcase
    end

    // Pipeline controls, next state and counter increments.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_hold  = 1'b0;
        state_nxt_s = RUN;
        fcnt_nxt_s  = fcnt_r;
        pend_nxt_s  = 1'b0;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        if (!rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            fcnt_nxt_s = '0;
        end else if (do_hold_s) begin
            // Freeze the front end; fcnt_r is left untouched so an interrupted flush resumes.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            exmem_hold  = 1'b1;
            stall_inc_s = 1'b1;
            state_nxt_s = MEM_WAIT;
            pend_nxt_s  = branch_taken || ((state_r == MEM_WAIT) && pend_r);
        end else if (do_flush_s) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_inc_s = pend_r;
            if (fcnt_r > FCNT_ONE) begin
                fcnt_nxt_s  = fcnt_r - FCNT_ONE;
                state_nxt_s = FLUSH;
            end else begin
                fcnt_nxt_s  = '0;
                state_nxt_s = RUN;
            end
        end else if (branch_taken) begin
            // Any coincident load-use is moot: that instruction is squashed.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_inc_s = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                fcnt_nxt_s  = FLUSH_LOAD;
                state_nxt_s = FLUSH;
            end else begin
                fcnt_nxt_s  = '0;
                state_nxt_s = RUN;
            end
        end else if (load_use_s) begin
            // One bubble suffices: next cycle the load has moved to MEM.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
            stall_inc_s = 1'b1;
        end else begin
            fcnt_nxt_s = '0;
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= RUN;
            fcnt_r  <= '0;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            fcnt_r  <= fcnt_nxt_s;
            pend_r  <= pend_nxt_s;
        end
    end

    assign state_o = rst ? state_r : STATE_W'(0);

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (stall_inc_s && (stall_cnt_r != '1)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_inc_s && (flush_cnt_r != '1)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    logic perf_unused_s;
    assign perf_unused_s = stall_inc_s ^ flush_inc_s;
    assign stall_cnt     = '0;
    assign flush_cnt     = '0;
`endif

endmodule
